// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, sampled mid-bit off a system-clock cycle counter.
// Latency: donerx rises HALF+9*BIT+1 cycles after the synchronised start edge (2 more from the pin).
// Backpressure: none; every byte is presented for exactly one cycle and rx_data holds until the next good frame.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active high; aborts any frame in progress
//   rx         serial line, asynchronous to clk, idles high
//   rx_data    last correctly framed byte
//   donerx     one-cycle pulse: rx_data has just been updated
//   frame_err  one-cycle pulse: stop bit was sampled low
//   busy       high whenever the receiver is not idle
//
// clk_freq/baud_rate must give at least 4 cycles per bit.
module uart_rx #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       donerx,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT  = clk_freq / baud_rate;
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT);

  // Counter values in the last cycle of a half-bit / full-bit interval.
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [1:0]      r_sync;
  logic            w_rx_s;

  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      r_rx_data;
  logic            r_donerx;
  logic            r_frame_err;

  logic            w_half;
  logic            w_tick;
  logic            w_busy;
  logic            w_sample_bit;
  logic            w_frame_ok;
  logic            w_frame_bad;
  logic            w_cnt_clr;

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rx_s = r_sync[1];

  // The counter starts at 0 in the cycle after the start edge is seen, so
  // "counter == N-1" marks absolute cycle N of the current interval.
  assign w_half = (r_cnt == HALF_LAST);
  assign w_tick = (r_cnt == BIT_LAST);

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_next = S_START;
      end
      S_START: begin
        // A start bit that is high again at its centre was a glitch.
        if (w_half) w_next = w_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_tick && (r_bit == 3'd7)) w_next = S_STOP;
      end
      S_STOP: begin
        // Leave at mid-stop so a start bit straight after the stop bit is caught.
        if (w_tick) w_next = w_rx_s ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        // A line held low must go high before another start can be seen.
        if (w_rx_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    w_busy       = (r_state != S_IDLE);
    w_sample_bit = 1'b0;
    w_frame_ok   = 1'b0;
    w_frame_bad  = 1'b0;
    unique case (r_state)
      S_DATA: begin
        w_sample_bit = w_tick;
      end
      S_STOP: begin
        w_frame_ok  = w_tick &&  w_rx_s;
        w_frame_bad = w_tick && !w_rx_s;
      end
      default: begin
      end
    endcase
    // Restart interval timing on every state change and after each data bit.
    w_cnt_clr = (r_state == S_IDLE) || (r_state == S_BREAK) ||
                (r_state != w_next) || w_sample_bit;
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_donerx    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == S_IDLE) begin
        r_bit <= '0;
      end else if (w_sample_bit) begin
        r_bit <= r_bit + 1'b1;
      end

      // LSB arrives first, so shift in from the top; after eight bits the
      // first one received sits in bit 0.
      if (w_sample_bit) begin
        r_shift <= {w_rx_s, r_shift[7:1]};
      end

      if (w_frame_ok) begin
        r_rx_data <= r_shift;
      end

      r_donerx    <= w_frame_ok;
      r_frame_err <= w_frame_bad;
    end
  end

  assign rx_data   = r_rx_data;
  assign donerx    = r_donerx;
  assign frame_err = r_frame_err;
  assign busy      = w_busy;

  // Both strobes are single-cycle and mutually exclusive by construction.
  a_excl : assert property (@(posedge clk) disable iff (rst) !(donerx && frame_err));
  a_done_pulse : assert property (@(posedge clk) disable iff (rst) donerx |=> !donerx);
  a_ferr_pulse : assert property (@(posedge clk) disable iff (rst) frame_err |=> !frame_err);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomised frames against a byte-level expectation model.
// Line stimulus is driven 1 time unit after each rising clk edge; outputs sampled on the falling edge.
// No backpressure on the receiver; the bench only observes strobes and the held byte.
module tb_uart_rx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 9600;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int HALF     = BIT / 2;
  // Pin edge to donerx: 2 synchroniser cycles, the detection cycle, then
  // the stop-bit centre at HALF+9*BIT, strobe one cycle later.
  localparam int LAT      = 3 + HALF + 9 * BIT;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       donerx;
  logic       frame_err;
  logic       busy;

  uart_rx #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .donerx   (donerx),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation of DUT strobes.
  int         n_done = 0;
  int         n_ferr = 0;
  int         n_both = 0;
  int         last_done_cyc = 0;
  bit         busy_seen = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (donerx) begin
      n_done++;
      last_done_cyc = cyc;
      got_q.push_back(rx_data);
    end
    if (frame_err) n_ferr++;
    if (donerx && frame_err) n_both++;
    if (busy) busy_seen = 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int fall_cyc = 0;

  // Start bit, eight data bits LSB first, then the stop level for stop_cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_cycles);
    fall_cyc = cyc;
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
    drive(stop_v, stop_cycles);
  endtask

  // Expectation model: the held byte and the strobe counts at frame level.
  logic [7:0] exp_data = 8'h00;
  int d0, f0, lat, kind, gap, glen;
  logic [7:0] rb;

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_donerx", donerx, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    drive(1'b1, 20);

    // 1: one good byte, latency near ~990 cycles.
    d0 = n_done; f0 = n_ferr;
    send_frame(8'hA5, 1'b1, BIT);
    exp_data = 8'hA5;
    lat = last_done_cyc - fall_cyc;
    check("t1_done_count", n_done - d0, 1);
    check("t1_ferr_count", n_ferr - f0, 0);
    check("t1_rx_data", rx_data, exp_data);
    check("t1_latency_window", (lat >= LAT - 2) && (lat <= LAT + 2), 1'b1);

    // 2: short low glitch is rejected.
    d0 = n_done; f0 = n_ferr; busy_seen = 0;
    drive(1'b0, 20);
    drive(1'b1, HALF);
    check("t2_busy_seen", busy_seen, 1'b1);
    check("t2_busy_idle", busy, 1'b0);
    check("t2_done_count", n_done - d0, 0);
    check("t2_ferr_count", n_ferr - f0, 0);
    check("t2_rx_data", rx_data, exp_data);

    // 3: low stop bit then line held low -> frame error, break until high.
    d0 = n_done; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 3 * BIT);
    check("t3_busy_in_break", busy, 1'b1);
    check("t3_ferr_count", n_ferr - f0, 1);
    check("t3_done_count", n_done - d0, 0);
    check("t3_rx_data", rx_data, exp_data);
    drive(1'b1, 5);
    check("t3_busy_released", busy, 1'b0);

    // 4: back-to-back bytes with no idle gap.
    got_q.delete(); d0 = n_done; f0 = n_ferr;
    send_frame(8'h00, 1'b1, BIT);
    send_frame(8'hFF, 1'b1, BIT);
    drive(1'b1, 10);
    exp_data = 8'hFF;
    check("t4_done_count", n_done - d0, 2);
    check("t4_ferr_count", n_ferr - f0, 0);
    check("t4_first_byte", (got_q.size() > 0) ? got_q[0] : 8'hXX, 8'h00);
    check("t4_second_byte", (got_q.size() > 1) ? got_q[1] : 8'hXX, 8'hFF);

    // 5: reset during data bit 3, then a clean frame.
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b1, HALF);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_data = 8'h00;
    check("t5_rx_data_rst", rx_data, exp_data);
    check("t5_donerx_rst", donerx, 1'b0);
    check("t5_frame_err_rst", frame_err, 1'b0);
    check("t5_busy_rst", busy, 1'b0);
    drive(1'b1, 2 * BIT);
    d0 = n_done; f0 = n_ferr;
    send_frame(8'h5A, 1'b1, BIT);
    exp_data = 8'h5A;
    check("t5_done_count", n_done - d0, 1);
    check("t5_rx_data", rx_data, exp_data);

    // 6: transmitter-style frame 0x81.
    d0 = n_done;
    send_frame(8'h81, 1'b1, BIT);
    exp_data = 8'h81;
    check("t6_done_count", n_done - d0, 1);
    check("t6_rx_data", rx_data, exp_data);

    // Randomised mix of good frames, framing errors and glitches.
    for (int k = 0; k < 16; k++) begin
      d0   = n_done; f0 = n_ferr;
      kind = $urandom_range(0, 3);
      rb   = 8'($urandom);
      gap  = $urandom_range(0, 30);
      if (kind == 1) begin
        send_frame(rb, 1'b0, $urandom_range(1, 3) * BIT);
        drive(1'b1, 4 + gap);
        check("rnd_ferr_count", n_ferr - f0, 1);
        check("rnd_ferr_done", n_done - d0, 0);
      end else if (kind == 2) begin
        glen = $urandom_range(1, HALF - 4);
        drive(1'b0, glen);
        drive(1'b1, HALF + 4 + gap);
        check("rnd_glitch_done", n_done - d0, 0);
        check("rnd_glitch_ferr", n_ferr - f0, 0);
      end else begin
        send_frame(rb, 1'b1, BIT);
        exp_data = rb;
        if (gap > 0) drive(1'b1, gap);
        check("rnd_done_count", n_done - d0, 1);
        check("rnd_ferr_none", n_ferr - f0, 0);
      end
      check("rnd_rx_data", rx_data, exp_data);
    end

    check("strobes_exclusive", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
